vdp1_cmd_sequencer: RTL and testbench

//  Walks the VDP1 command list in VRAM: fetches 32-byte command tables word by word, applies END/skip and

---
 rtl/vdp1_cmd_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_vdp1_cmd_sequencer.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vdp1_cmd_sequencer.sv
// vdp1_cmd_sequencer
//   Walks the VDP1 command list in VRAM one 16-word table at a time. It
//   resolves END, skip and the jump modes (next/assign/call/return) and
//   hands each executable table to the draw engine over valid/ready.
// Ports
//   CLK, RST_N          clock, asynchronous active-low reset
//   START, ABORT        1-cycle pulses: (re)start list walk / force end
//   VRAM_A/RD/D/RDY     word read port; A held stable while RD until RDY
//   CMD_TBL/VALID/READY fetched table (word 0 in [255:240]) to draw engine
//   COPR, LOPR          current / last-ended table address (byte addr / 8)
//   CEF, BEF, BUSY      current/previous frame end flags, walker active
module vdp1_cmd_sequencer #(
  parameter int unsigned TBL_WORDS = 16,
  parameter logic [17:0] LIST_BASE = 18'h0
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         START,
  input  logic         ABORT,
  output logic [17:0]  VRAM_A,
  output logic         VRAM_RD,
  input  logic [15:0]  VRAM_D,
  input  logic         VRAM_RDY,
  output logic [255:0] CMD_TBL,
  output logic         CMD_VALID,
  input  logic         CMD_READY,
  output logic [15:0]  COPR,
  output logic [15:0]  LOPR,
  output logic         CEF,
  output logic         BEF,
  output logic         BUSY
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_CTRL, S_RD_LINK, S_RD_BODY, S_ISSUE, S_NEXT
  } state_t;

  state_t      state_q;
  logic [17:0] cur_q;
  logic [17:0] ret_q;
  logic        ret_v_q;
  logic [3:0]  idx_q;
  logic [17:0] addr_q;
  logic        rd_q;
  logic        valid_q;
  logic [15:0] lopr_q;
  logic        cef_q;
  logic        bef_q;
  logic [15:0] tbl_q [TBL_WORDS];

  logic        comm_ok;
  logic        skip;
  logic [17:0] seq_addr;
  logic [17:0] link_addr;
  logic [17:0] jump_addr;
  logic [3:0]  idx_inc;

  // Jump/skip decode is taken from the captured CTRL and LINK words.
  always_comb begin
    comm_ok = 1'b0;
    case (tbl_q[0][3:0])
      4'h0, 4'h1, 4'h2, 4'h4, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA: comm_ok = 1'b1;
      default: comm_ok = 1'b0;
    endcase
    skip      = tbl_q[0][14] | (tbl_q[0][13:12] == 2'b11) | ~comm_ok;
    seq_addr  = cur_q + 18'(TBL_WORDS);
    link_addr = {tbl_q[1], 2'b00};
    idx_inc   = idx_q + 4'd1;
    jump_addr = seq_addr;
    case (tbl_q[0][13:12])
      2'b00:        jump_addr = seq_addr;
      2'b01, 2'b10: jump_addr = link_addr;
      default:      jump_addr = ret_v_q ? ret_q : seq_addr;
    endcase
  end

  always_comb begin
    CMD_TBL = '0;
    for (int unsigned i = 0; i < TBL_WORDS; i++) begin
      CMD_TBL[(TBL_WORDS-1-i)*16 +: 16] = tbl_q[i];
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      cur_q   <= '0;
      ret_q   <= '0;
      ret_v_q <= 1'b0;
      idx_q   <= '0;
      addr_q  <= '0;
      rd_q    <= 1'b0;
      valid_q <= 1'b0;
      lopr_q  <= '0;
      cef_q   <= 1'b0;
      bef_q   <= 1'b0;
      for (int unsigned i = 0; i < TBL_WORDS; i++) tbl_q[i] <= '0;
    end else if (START) begin
      // START outranks ABORT and restarts from any state.
      state_q <= S_RD_CTRL;
      bef_q   <= cef_q;
      cef_q   <= 1'b0;
      cur_q   <= LIST_BASE;
      ret_v_q <= 1'b0;
      idx_q   <= '0;
      addr_q  <= LIST_BASE;
      rd_q    <= 1'b1;
      valid_q <= 1'b0;
    end else if (ABORT) begin
      state_q <= S_IDLE;
      rd_q    <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_RD_CTRL: if (VRAM_RDY) begin
          tbl_q[0] <= VRAM_D;
          if (VRAM_D[15]) begin
            cef_q   <= 1'b1;
            lopr_q  <= cur_q[17:2];
            rd_q    <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            idx_q   <= 4'd1;
            addr_q  <= cur_q + 18'd1;
            state_q <= S_RD_LINK;
          end
        end
        S_RD_LINK: if (VRAM_RDY) begin
          tbl_q[1] <= VRAM_D;
          if (skip) begin
            rd_q    <= 1'b0;
            state_q <= S_NEXT;
          end else begin
            idx_q   <= 4'd2;
            addr_q  <= cur_q + 18'd2;
            state_q <= S_RD_BODY;
          end
        end
        S_RD_BODY: if (VRAM_RDY) begin
          tbl_q[idx_q] <= VRAM_D;
          if (idx_q == 4'(TBL_WORDS - 1)) begin
            rd_q    <= 1'b0;
            valid_q <= 1'b1;
            state_q <= S_ISSUE;
          end else begin
            idx_q  <= idx_inc;
            addr_q <= cur_q + 18'(idx_inc);
          end
        end
        S_ISSUE: if (CMD_READY) begin
          valid_q <= 1'b0;
          state_q <= S_NEXT;
        end
        S_NEXT: begin
          case (tbl_q[0][13:12])
            2'b10: if (!ret_v_q) begin
              ret_q   <= seq_addr;
              ret_v_q <= 1'b1;
            end
            2'b11: ret_v_q <= 1'b0;
            default: ;
          endcase
          cur_q   <= jump_addr;
          addr_q  <= jump_addr;
          idx_q   <= '0;
          rd_q    <= 1'b1;
          state_q <= S_RD_CTRL;
        end
        default: ;
      endcase
    end
  end

  assign VRAM_A    = addr_q;
  assign VRAM_RD   = rd_q;
  assign CMD_VALID = valid_q;
  assign COPR      = cur_q[17:2];
  assign LOPR      = lopr_q;
  assign CEF       = cef_q;
  assign BEF       = bef_q;
  assign BUSY      = (state_q != S_IDLE);

endmodule

// File: tb/tb_vdp1_cmd_sequencer.sv
module tb_vdp1_cmd_sequencer;

  logic         CLK = 1'b0;
  logic         RST_N, START, ABORT;
  logic [17:0]  VRAM_A;
  logic         VRAM_RD;
  logic [15:0]  VRAM_D;
  logic         VRAM_RDY;
  logic [255:0] CMD_TBL;
  logic         CMD_VALID, CMD_READY;
  logic [15:0]  COPR, LOPR;
  logic         CEF, BEF, BUSY;

  vdp1_cmd_sequencer #(.TBL_WORDS(16), .LIST_BASE(18'h0)) dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .ABORT(ABORT),
    .VRAM_A(VRAM_A), .VRAM_RD(VRAM_RD), .VRAM_D(VRAM_D), .VRAM_RDY(VRAM_RDY),
    .CMD_TBL(CMD_TBL), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
    .COPR(COPR), .LOPR(LOPR), .CEF(CEF), .BEF(BEF), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  logic [15:0]  mem [0:262143];
  logic [17:0]  exp_rd_q [$];
  logic [255:0] exp_tbl_q [$];
  int unsigned  n_cmp = 0, n_err = 0;
  int unsigned  ready_mode = 0, ack_limit = 0, rsp_cnt = 0, lat = 0, vcnt = 0;
  bit           late_pulse = 0;
  logic         m_cef = 0, m_bef = 0;
  logic [15:0]  m_lopr = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Reference walk of the list held in mem, from the command-list rules.
  task automatic model_walk(input int unsigned max_tbl, output bit ended);
    logic [17:0]  cur, ret;
    bit           rv, exec;
    logic [15:0]  ctrl, link;
    logic [255:0] t;
    m_bef = m_cef; m_cef = 0; cur = 18'h0; ret = 0; rv = 0; ended = 0;
    for (int unsigned n = 0; n < max_tbl && !ended; n++) begin
      ctrl = mem[cur];
      exp_rd_q.push_back(cur);
      if (ctrl[15]) begin
        m_cef = 1; m_lopr = 16'(cur >> 2); ended = 1;
      end else begin
        link = mem[cur + 18'd1];
        exp_rd_q.push_back(cur + 18'd1);
        exec = !ctrl[14] && ctrl[13:12] != 2'b11 &&
               (ctrl[3:0] inside {4'h0, 4'h1, 4'h2, 4'h4, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA});
        if (exec) begin
          t = '0;
          for (int unsigned w = 0; w < 16; w++) begin
            if (w >= 2) exp_rd_q.push_back(cur + 18'(w));
            t = {t[239:0], mem[cur + 18'(w)]};
          end
          exp_tbl_q.push_back(t);
        end
        case (ctrl[13:12])
          2'b00: cur = cur + 18'd16;
          2'b01: cur = 18'(link) * 18'd4;
          2'b10: begin
            if (!rv) begin ret = cur + 18'd16; rv = 1; end
            cur = 18'(link) * 18'd4;
          end
          default: if (rv) begin cur = ret; rv = 0; end else cur = cur + 18'd16;
        endcase
      end
    end
  endtask

  task automatic set_tbl(input logic [17:0] a, input logic [15:0] ctrl, input logic [15:0] link);
    mem[a] = ctrl;
    mem[a + 18'd1] = link;
    for (int unsigned w = 2; w < 16; w++) mem[a + 18'(w)] = 16'($urandom);
  endtask

  task automatic fill_random();
    for (int unsigned a = 0; a < 1280; a++) begin
      case (a % 4)
        0: begin
          if ($urandom_range(0, 9) == 0) mem[a] = 16'h8000 | 16'($urandom_range(0, 255));
          else mem[a] = {1'b0, ($urandom_range(0, 7) == 0), 2'($urandom_range(0, 3)),
                         8'($urandom), 4'($urandom_range(0, 15))};
        end
        1: mem[a] = 16'($urandom_range(0, 255));
        default: mem[a] = 16'($urandom);
      endcase
    end
  endtask

  task automatic pulse_start();
    @(negedge CLK); START = 1;
    @(negedge CLK); START = 0;
  endtask

  task automatic run_scn(input string nm, input int unsigned max_tbl, input int unsigned rmode);
    bit ended;
    int unsigned cyc;
    model_walk(max_tbl, ended);
    ready_mode = rmode;
    pulse_start();
    cyc = 0;
    if (ended) begin
      while (BUSY && cyc < 2000) begin @(negedge CLK); cyc++; end
      chk({nm, "_done"}, BUSY, 1'b0);
      chk({nm, "_copr"}, COPR, m_lopr);
    end else begin
      while ((exp_rd_q.size() != 0 || exp_tbl_q.size() != 0) && cyc < 2000) begin
        @(negedge CLK); cyc++;
      end
      repeat (3) @(negedge CLK);
      chk({nm, "_still_busy"}, BUSY, 1'b1);
      ABORT = 1;
      @(negedge CLK); ABORT = 0;
      chk({nm, "_abort_idle"}, BUSY, 1'b0);
      chk({nm, "_abort_rd"}, VRAM_RD, 1'b0);
    end
    chk({nm, "_cef"}, CEF, m_cef);
    chk({nm, "_bef"}, BEF, m_bef);
    chk({nm, "_lopr"}, LOPR, m_lopr);
    chk({nm, "_rd_left"}, exp_rd_q.size(), 0);
    chk({nm, "_tbl_left"}, exp_tbl_q.size(), 0);
    exp_rd_q.delete(); exp_tbl_q.delete();
  endtask

  // VRAM responder: random latency, acks only reads the model expects.
  initial begin
    VRAM_RDY = 0; VRAM_D = 0;
    forever begin
      @(posedge CLK); #1;
      VRAM_RDY = 0;
      if (late_pulse) begin
        VRAM_RDY = 1; VRAM_D = 16'($urandom); late_pulse = 0;
      end else if (VRAM_RD && exp_rd_q.size() > 0 && (ack_limit == 0 || rsp_cnt < ack_limit)) begin
        if (lat == 0) begin
          VRAM_D = mem[VRAM_A]; VRAM_RDY = 1; rsp_cnt++;
          lat = $urandom_range(0, 2);
        end else lat--;
      end
    end
  end

  // Draw-engine ready: always / random / held low 20 cycles of VALID.
  initial begin
    CMD_READY = 0;
    forever begin
      @(posedge CLK); #1;
      if (CMD_VALID) vcnt++; else vcnt = 0;
      case (ready_mode)
        0: CMD_READY = 1;
        1: CMD_READY = 1'($urandom_range(0, 1));
        default: CMD_READY = (vcnt > 20);
      endcase
    end
  end

  // Monitor / scoreboard.
  initial begin
    logic [255:0] prev_tbl;
    logic [255:0] et;
    logic [17:0]  ea;
    bit           hold_prev;
    prev_tbl = '0; hold_prev = 0;
    forever begin
      @(negedge CLK);
      if (RST_N) begin
        if (VRAM_RD && VRAM_RDY) begin
          if (exp_rd_q.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL rd_unexpected: actual addr=%0h required no read", VRAM_A);
          end else begin
            ea = exp_rd_q.pop_front();
            chk("vram_addr", VRAM_A, ea);
          end
        end
        if (CMD_VALID && CMD_READY) begin
          if (exp_tbl_q.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL issue_unexpected: actual tbl=%0h required no issue", CMD_TBL);
          end else begin
            et = exp_tbl_q.pop_front();
            chk("cmd_tbl", CMD_TBL, et);
          end
        end
        if (hold_prev) begin
          chk("valid_hold", CMD_VALID, 1'b1);
          chk("tbl_hold", CMD_TBL, prev_tbl);
          chk("no_rd_in_issue", VRAM_RD, 1'b0);
        end
        hold_prev = CMD_VALID && !CMD_READY && !START && !ABORT;
        prev_tbl  = CMD_TBL;
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int unsigned cyc;
    logic [15:0] sv_lopr;
    bit ended;
    RST_N = 0; START = 0; ABORT = 0;
    repeat (3) @(negedge CLK);
    chk("rst_vram_a", VRAM_A, 0);
    chk("rst_vram_rd", VRAM_RD, 0);
    chk("rst_cmd_tbl", CMD_TBL, 0);
    chk("rst_cmd_valid", CMD_VALID, 0);
    chk("rst_copr", COPR, 0);
    chk("rst_lopr", LOPR, 0);
    chk("rst_cef", CEF, 0);
    chk("rst_bef", BEF, 0);
    chk("rst_busy", BUSY, 0);
    RST_N = 1;

    mem[0] = 16'h8000;
    run_scn("end_first", 40, 0);

    set_tbl(18'h0, 16'h0000, 16'h1234);
    set_tbl(18'h10, 16'h8000, 16'h0);
    run_scn("nspr_then_end", 40, 0);
    run_scn("ready_stall", 40, 2);

    set_tbl(18'h0, 16'h2000, 16'h0100);
    set_tbl(18'h400, 16'h3000, 16'h0);
    set_tbl(18'h10, 16'h8000, 16'h0);
    run_scn("call_return", 40, 1);

    set_tbl(18'h0, 16'h2001, 16'h0040);
    set_tbl(18'h100, 16'h2002, 16'h0080);
    set_tbl(18'h200, 16'h3000, 16'h0);
    set_tbl(18'h10, 16'h3000, 16'h0);
    set_tbl(18'h20, 16'h8000, 16'h0);
    run_scn("nested_call", 40, 1);

    set_tbl(18'h0, 16'h1004, 16'hFFFC);
    set_tbl(18'h3FFF0, 16'h0005, 16'h0);
    run_scn("wrap_loop", 3, 0);

    // Abort during body word 7 with a late acknowledge after the abort.
    set_tbl(18'h0, 16'h0000, 16'h0);
    set_tbl(18'h10, 16'h8000, 16'h0);
    sv_lopr = m_lopr;
    model_walk(40, ended);
    m_cef = 0; m_lopr = sv_lopr;
    ready_mode = 0; rsp_cnt = 0; ack_limit = 7;
    pulse_start();
    cyc = 0;
    while (rsp_cnt < 7 && cyc < 2000) begin @(negedge CLK); cyc++; end
    repeat (2) @(negedge CLK);
    chk("abort_rd_pending", VRAM_RD, 1'b1);
    chk("abort_word7_addr", VRAM_A, 18'h7);
    ABORT = 1; late_pulse = 1;
    @(negedge CLK); ABORT = 0;
    chk("abort_busy", BUSY, 1'b0);
    chk("abort_rd", VRAM_RD, 1'b0);
    chk("abort_valid", CMD_VALID, 1'b0);
    chk("abort_cef", CEF, m_cef);
    chk("abort_lopr", LOPR, m_lopr);
    repeat (2) @(negedge CLK);
    chk("abort_late_rdy_ignored", BUSY, 1'b0);
    chk("abort_rd_left", exp_rd_q.size(), 10);
    exp_rd_q.delete(); exp_tbl_q.delete();
    ack_limit = 0;
    run_scn("restart_after_abort", 40, 0);

    for (int unsigned k = 0; k < 25; k++) begin
      fill_random();
      run_scn("random", 12, $urandom_range(0, 1));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
